psum_accum: RTL and testbench

PSUM_ACCUM -- requirements
Module: psum_accum

---
 rtl/psum_accum.sv | 175 +++++++++++++++++
 tb/tb_psum_accum.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/psum_accum.sv
`default_nettype none
// ============================================================================
//  Module   : psum_accum
//  Purpose  : Partial-sum accumulator. Drains rows from a show-ahead output
//             FIFO into a psum BRAM. On a first pass the row overwrites the
//             BRAM entry. On later passes it is added lane by lane
//             (signed, wrapping) to the value read back from the BRAM.
//  Ports    : clk, reset                  - clock, sync active-high reset
//             start, first_pass,
//             num_entries                 - pass control, sampled in IDLE
//             ofifo_valid, ofifo_data,
//             ofifo_rd                    - FIFO head / pop
//             bram_en_b, bram_addr_b,
//             bram_dout_b                 - BRAM read port (1-cycle latency)
//             bram_we_a, bram_addr_a,
//             bram_din_a                  - BRAM write port
//             busy, done                  - status (done is a 1-cycle pulse)
//  Revision : 1.0 - initial release
// ============================================================================
module psum_accum #(
  parameter int DATA_WIDTH = 128,
  parameter int PSUM_WIDTH = 16,
  parameter int ADDR_WIDTH = 9,
  parameter int DEPTH      = 324
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  first_pass,
  input  logic [ADDR_WIDTH-1:0] num_entries,
  input  logic                  ofifo_valid,
  input  logic [DATA_WIDTH-1:0] ofifo_data,
  output logic                  ofifo_rd,
  output logic                  bram_en_b,
  output logic [ADDR_WIDTH-1:0] bram_addr_b,
  input  logic [DATA_WIDTH-1:0] bram_dout_b,
  output logic                  bram_we_a,
  output logic [ADDR_WIDTH-1:0] bram_addr_a,
  output logic [DATA_WIDTH-1:0] bram_din_a,
  output logic                  busy,
  output logic                  done
);

  localparam int c_lanes = DATA_WIDTH / PSUM_WIDTH;
  // Counters carry one extra bit so issue_addr can reach count == DEPTH
  // even when DEPTH equals 2**ADDR_WIDTH.
  localparam int              c_cw        = ADDR_WIDTH + 1;
  localparam logic [c_cw-1:0] c_depth     = c_cw'(DEPTH);
  localparam logic [c_cw-1:0] c_depth_m1  = c_cw'(DEPTH - 1);
  localparam logic [c_cw-1:0] c_one       = c_cw'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic                  r_first_pass;
  logic [c_cw-1:0]       r_count;
  logic [c_cw-1:0]       r_issue_addr;
  logic [DATA_WIDTH-1:0] r_stage;
  logic [ADDR_WIDTH-1:0] r_waddr;
  logic                  r_we;

  logic [c_cw-1:0]       w_num_ext;
  logic [c_cw-1:0]       w_num_clamped;
  logic                  w_accept_start;
  logic                  w_pop;
  logic                  w_last_pop;
  logic [DATA_WIDTH-1:0] w_sum;

  assign w_num_ext      = {1'b0, num_entries};
  assign w_num_clamped  = (w_num_ext > c_depth) ? c_depth : w_num_ext;
  assign w_accept_start = (r_state == S_IDLE) && start;

  // Reset gates the pop so nothing leaves the FIFO while the pass is aborted.
  assign w_pop      = (r_state == S_RUN) && ofifo_valid &&
                      (r_issue_addr < r_count) && !reset;
  assign w_last_pop = w_pop && (r_issue_addr == (r_count - c_one));

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next state and status outputs
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    busy        = 1'b0;
    done        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = (w_num_clamped == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        busy = 1'b1;
        if (w_last_pop) begin
          w_state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        busy        = 1'b1;
        w_state_nxt = S_DONE;
      end
      S_DONE: begin
        done        = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
    if (reset) begin
      busy = 1'b0;
      done = 1'b0;
    end
  end

  // --------------------------------------------------------------------------
  // Datapath: pass parameters, issue pointer, one-deep write stage
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_first_pass <= 1'b0;
      r_count      <= '0;
      r_issue_addr <= '0;
      r_stage      <= '0;
      r_waddr      <= '0;
      r_we         <= 1'b0;
    end else begin
      r_we <= w_pop;
      if (w_accept_start) begin
        r_first_pass <= first_pass;
        r_count      <= w_num_clamped;
        r_issue_addr <= '0;
      end
      if (w_pop) begin
        r_stage      <= ofifo_data;
        r_waddr      <= r_issue_addr[ADDR_WIDTH-1:0];
        r_issue_addr <= r_issue_addr + c_one;
      end
    end
  end

  // Per-lane add; each lane wraps independently, no carry crosses lanes.
  for (genvar i = 0; i < c_lanes; i++) begin : g_lane
    assign w_sum[i*PSUM_WIDTH +: PSUM_WIDTH] =
      r_stage[i*PSUM_WIDTH +: PSUM_WIDTH] + bram_dout_b[i*PSUM_WIDTH +: PSUM_WIDTH];
  end

  assign ofifo_rd    = w_pop;
  assign bram_en_b   = w_pop && !r_first_pass;
  // Once the final row has issued the pointer rests at count, which can be
  // DEPTH; saturate so the idle read address stays inside the array.
  assign bram_addr_b = (r_issue_addr > c_depth_m1) ? c_depth_m1[ADDR_WIDTH-1:0]
                                                   : r_issue_addr[ADDR_WIDTH-1:0];
  assign bram_we_a   = r_we && !reset;
  assign bram_addr_a = r_waddr;
  assign bram_din_a  = r_first_pass ? r_stage : w_sum;

endmodule
`default_nettype wire

// File: tb/tb_psum_accum.sv
`default_nettype none
// ============================================================================
//  Module   : tb_psum_accum
//  Purpose  : Directed self-checking bench for psum_accum with a show-ahead
//             FIFO model and a 1-cycle-latency BRAM model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_psum_accum;

  localparam int DW    = 128;
  localparam int AW    = 9;
  localparam int DEPTH = 324;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          first_pass;
  logic [AW-1:0] num_entries;
  logic          valid_gate;
  logic          ofifo_valid;
  logic [DW-1:0] ofifo_data;
  logic          ofifo_rd;
  logic          bram_en_b;
  logic [AW-1:0] bram_addr_b;
  logic [DW-1:0] bram_dout_b = '0;
  logic          bram_we_a;
  logic [AW-1:0] bram_addr_a;
  logic [DW-1:0] bram_din_a;
  logic          busy;
  logic          done;

  always #5 clk = ~clk;

  psum_accum #(
    .DATA_WIDTH (DW),
    .PSUM_WIDTH (16),
    .ADDR_WIDTH (AW),
    .DEPTH      (DEPTH)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .first_pass  (first_pass),
    .num_entries (num_entries),
    .ofifo_valid (ofifo_valid),
    .ofifo_data  (ofifo_data),
    .ofifo_rd    (ofifo_rd),
    .bram_en_b   (bram_en_b),
    .bram_addr_b (bram_addr_b),
    .bram_dout_b (bram_dout_b),
    .bram_we_a   (bram_we_a),
    .bram_addr_a (bram_addr_a),
    .bram_din_a  (bram_din_a),
    .busy        (busy),
    .done        (done)
  );

  // Show-ahead FIFO model: the initial block appends, the pop advances head.
  logic [DW-1:0] fifo_mem [0:511];
  int            fifo_cnt  = 0;
  int            fifo_head = 0;
  assign ofifo_valid = valid_gate && (fifo_head < fifo_cnt);
  assign ofifo_data  = fifo_mem[fifo_head[8:0]];
  always @(posedge clk) if (ofifo_rd) fifo_head <= fifo_head + 1;

  // BRAM model: synchronous read, synchronous write.
  logic [DW-1:0] mem [0:DEPTH-1];
  always @(posedge clk) begin
    if (bram_en_b) bram_dout_b <= mem[bram_addr_b];
    if (bram_we_a) mem[bram_addr_a] <= bram_din_a;
  end

  // Event logs, sampled mid-cycle.
  int            cyc = 0;
  int            pop_cyc [$];
  int            wr_cyc  [$];
  int            wr_addr [$];
  logic [DW-1:0] wr_data [$];
  int            done_cyc[$];
  int            en_cnt    = 0;
  bit            range_bad = 1'b0;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (ofifo_rd)  pop_cyc.push_back(cyc);
    if (bram_en_b) en_cnt <= en_cnt + 1;
    if (bram_we_a) begin
      wr_cyc.push_back(cyc);
      wr_addr.push_back(int'(bram_addr_a));
      wr_data.push_back(bram_din_a);
    end
    if (done) done_cyc.push_back(cyc);
    if (int'(bram_addr_a) > DEPTH - 1 || int'(bram_addr_b) > DEPTH - 1) range_bad <= 1'b1;
  end

  int n_vec = 0;
  int n_err = 0;
  int st_cyc;
  int pb, wb, db, eb;

  function automatic logic [DW-1:0] rep(input logic [15:0] v);
    return {8{v}};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chki(input string tag, input int obs, input int exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [DW-1:0] d);
    fifo_mem[fifo_cnt] = d;
    fifo_cnt++;
  endtask

  task automatic mark;
    pb = pop_cyc.size();
    wb = wr_cyc.size();
    db = done_cyc.size();
    eb = en_cnt;
  endtask

  // Called just after a clock edge; drives start for exactly one cycle and
  // scrambles the sampled inputs afterwards to expose any missing latch.
  task automatic do_start(input bit fp, input int n);
    start       = 1'b1;
    first_pass  = fp;
    num_entries = AW'(n);
    st_cyc      = cyc;
    tick();
    start       = 1'b0;
    first_pass  = ~fp;
    num_entries = '0;
  endtask

  task automatic wait_done(input int budget, input string tag);
    int k;
    k = 0;
    while (k < budget && done_cyc.size() == db) begin
      tick();
      k++;
    end
    chki(tag, int'(done_cyc.size() > db), 1);
  endtask

  initial begin
    reset       = 1'b1;
    start       = 1'b1;
    first_pass  = 1'b1;
    num_entries = AW'(4);
    valid_gate  = 1'b1;
    push(rep(16'h0001));
    tick();
    tick();
    // ---------------- reset state ----------------
    chk("rst_outs", DW'({ofifo_rd, bram_en_b, bram_we_a, busy, done}), '0);
    chk("rst_waddr", DW'(bram_addr_a), '0);
    reset = 1'b0;
    start = 1'b0;
    tick();
    chk("rst_idle", DW'({busy, ofifo_rd}), '0);

    // ---------------- first pass, 4 rows of 0x0001 ----------------
    for (int i = 1; i < 4; i++) push(rep(16'h0001));
    mark();
    do_start(1'b1, 4);
    chk("t1_busy", DW'(busy), DW'(1));
    wait_done(20, "t1_done_seen");
    chki("t1_pops", pop_cyc.size() - pb, 4);
    chki("t1_writes", wr_cyc.size() - wb, 4);
    chki("t1_first_pop", pop_cyc[pb], st_cyc + 1);
    for (int i = 0; i < 4; i++) begin
      chki("t1_addr", wr_addr[wb+i], i);
      chk("t1_data", wr_data[wb+i], rep(16'h0001));
      chki("t1_lat", wr_cyc[wb+i], pop_cyc[pb+i] + 1);
    end
    chki("t1_back2back", wr_cyc[wb+3], wr_cyc[wb] + 3);
    chki("t1_no_read", en_cnt - eb, 0);
    chki("t1_done_time", done_cyc[db], pop_cyc[pb+3] + 2);
    chki("t1_done_width", done_cyc.size() - db, 1);
    chk("t1_idle", DW'(busy), '0);

    // ---------------- accumulate with lane wrap ----------------
    push(rep(16'h7FFF)); push(rep(16'h7FFF)); push(rep(16'hFFFE)); push(rep(16'hFFFE));
    mark();
    do_start(1'b1, 4);
    wait_done(20, "t2_pre_done");
    push(rep(16'h0001)); push(rep(16'h0001)); push(rep(16'h0003)); push(rep(16'h0003));
    mark();
    do_start(1'b0, 4);
    wait_done(20, "t2_acc_done");
    chki("t2_reads", en_cnt - eb, 4);
    chk("t2_mem0", mem[0], rep(16'h8000));
    chk("t2_mem1", mem[1], rep(16'h8000));
    chk("t2_mem2", mem[2], rep(16'h0001));
    chk("t2_mem3", mem[3], rep(16'h0001));

    // ---------------- stall: valid 1,0,1,0 ----------------
    push(rep(16'h0001)); push(rep(16'h0001));
    mark();
    valid_gate = 1'b1;
    do_start(1'b0, 2);
    tick();
    valid_gate = 1'b0;
    #1;
    chk("t3_stall_rd", DW'({ofifo_rd, bram_en_b}), '0);
    chk("t3_we_pop0", DW'(bram_we_a), DW'(1));
    tick();
    chk("t3_we_gap", DW'(bram_we_a), '0);
    valid_gate = 1'b1;
    tick();
    valid_gate = 1'b0;
    wait_done(20, "t3_done");
    valid_gate = 1'b1;
    chki("t3_pops", pop_cyc.size() - pb, 2);
    chki("t3_writes", wr_cyc.size() - wb, 2);
    chki("t3_pop_gap", pop_cyc[pb+1], pop_cyc[pb] + 2);
    chki("t3_lat0", wr_cyc[wb], pop_cyc[pb] + 1);
    chki("t3_lat1", wr_cyc[wb+1], pop_cyc[pb+1] + 1);
    chki("t3_addr0", wr_addr[wb], 0);
    chki("t3_addr1", wr_addr[wb+1], 1);
    chki("t3_reads", en_cnt - eb, 2);
    chk("t3_mem0", mem[0], rep(16'h8001));
    chk("t3_mem1", mem[1], rep(16'h8001));

    // ---------------- num_entries = 0 ----------------
    push(rep(16'h0000));
    mark();
    do_start(1'b1, 0);
    chk("t4_done_now", DW'({done, busy}), DW'(2'b10));
    tick();
    tick();
    chki("t4_pops", pop_cyc.size() - pb, 0);
    chki("t4_writes", wr_cyc.size() - wb, 0);
    chki("t4_done_cnt", done_cyc.size() - db, 1);
    chki("t4_done_time", done_cyc[db], st_cyc + 1);

    // ---------------- num_entries = 400 clamps to 324 ----------------
    for (int k = 1; k < DEPTH; k++) push(rep(16'(k)));
    mark();
    do_start(1'b1, 400);
    wait_done(400, "t5_done");
    chki("t5_writes", wr_cyc.size() - wb, DEPTH);
    chki("t5_last_addr", wr_addr[wb+DEPTH-1], DEPTH - 1);
    begin
      int bad;
      bad = 0;
      for (int i = 0; i < DEPTH; i++) if (wr_addr[wb+i] != i) bad++;
      chki("t5_ascending", bad, 0);
    end
    chk("t5_mem0", mem[0], rep(16'h0000));
    chk("t5_mem323", mem[DEPTH-1], rep(16'(DEPTH - 1)));
    chki("t5_fifo_drained", fifo_head, fifo_cnt);

    // ---------------- reset after pop of address 5 ----------------
    for (int k = 0; k < 10; k++) push(rep(16'h0100 + 16'(k)));
    mark();
    do_start(1'b1, 10);
    begin
      int k;
      k = 0;
      while (k < 30 && (pop_cyc.size() - pb) < 6) begin
        tick();
        k++;
      end
    end
    chki("t6_six_pops", pop_cyc.size() - pb, 6);
    reset = 1'b1;
    #1;
    chk("t6_rst_outs", DW'({ofifo_rd, bram_en_b, bram_we_a, busy, done}), '0);
    tick();
    reset = 1'b0;
    tick();
    tick();
    tick();
    chki("t6_writes", wr_cyc.size() - wb, 5);
    chki("t6_last_addr", wr_addr[wr_addr.size()-1], 4);
    chk("t6_mem5_kept", mem[5], rep(16'h0005));
    chki("t6_no_done", done_cyc.size() - db, 0);
    chk("t6_idle", DW'(busy), '0);
    mark();
    do_start(1'b1, 4);
    wait_done(20, "t6_fresh_done");
    chki("t6_fresh_writes", wr_cyc.size() - wb, 4);
    chki("t6_fresh_addr0", wr_addr[wb], 0);
    chk("t6_fresh_data0", wr_data[wb], rep(16'h0106));
    chk("t6_fresh_mem3", mem[3], rep(16'h0109));

    // ---------------- start during RUN is ignored ----------------
    for (int k = 0; k < 3; k++) push(rep(16'h0A0A + 16'(k)));
    mark();
    do_start(1'b1, 3);
    start       = 1'b1;
    first_pass  = 1'b0;
    num_entries = AW'(1);
    tick();
    start = 1'b0;
    wait_done(20, "t7_done");
    tick();
    tick();
    tick();
    chki("t7_writes", wr_cyc.size() - wb, 3);
    chki("t7_no_read", en_cnt - eb, 0);
    chki("t7_one_done", done_cyc.size() - db, 1);
    chk("t7_mem2", mem[2], rep(16'h0A0C));

    chki("addr_range", int'(range_bad), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
